// File: rtl/siphash_padder_if.sv
//==============================================================================
// siphash_padder_if: message byte stream (start + valid/ready bytes) into the padder
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface siphash_padder_if;
  logic       start;
  logic       start_empty;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  modport master (
    output start, start_empty, in_valid, in_data, in_last,
    input  in_ready
  );

  modport slave (
    input  start, start_empty, in_valid, in_data, in_last,
    output in_ready
  );
endinterface

`default_nettype wire

// File: rtl/siphash_padder.sv
//==============================================================================
// siphash_padder: packs a byte stream into SipHash message words, appends the length
// padding and sequences the core; SIPHASH_PADDER_STATS_EN builds the compress counter.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module siphash_padder (
  input  wire logic         clk,
  input  wire logic         reset_n,
  siphash_padder_if.slave   stream,
  output logic              core_initalize,
  output logic              core_compress,
  output logic              core_finalize,
  output logic [63:0]       core_mi,
  input  wire logic         core_ready,
  input  wire logic         core_word_valid,
  output logic              busy,
  output logic              done,
  output logic [31:0]       blocks_ctr
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT    = 4'd1,
    COLLECT = 4'd2,
    COMP    = 4'd3,
    CWAIT   = 4'd4,
    PAD     = 4'd5,
    FCOMP   = 4'd6,
    FWAIT   = 4'd7,
    FIN     = 4'd8,
    DWAIT   = 4'd9,
    DONE    = 4'd10
  } state_t;

  state_t      state;
  logic [63:0] word_reg;
  logic [2:0]  lane_reg;
  logic [7:0]  len_reg;
  logic        last_pending;
  logic        empty_reg;

  assign core_mi = word_reg;

  // Outputs are registered alongside each transition so they track the state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      word_reg        <= 64'd0;
      lane_reg        <= 3'd0;
      len_reg         <= 8'd0;
      last_pending    <= 1'b0;
      empty_reg       <= 1'b0;
      stream.in_ready <= 1'b0;
      core_initalize  <= 1'b0;
      core_compress   <= 1'b0;
      core_finalize   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      core_initalize <= 1'b0;
      core_compress  <= 1'b0;
      core_finalize  <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (stream.start && core_ready) begin
            state          <= INIT;
            len_reg        <= 8'd0;
            lane_reg       <= 3'd0;
            word_reg       <= 64'd0;
            empty_reg      <= stream.start_empty;
            core_initalize <= 1'b1;
            busy           <= 1'b1;
          end
        end
        INIT: begin
          if (empty_reg) begin
            state <= PAD;
          end else begin
            state           <= COLLECT;
            stream.in_ready <= 1'b1;
          end
        end
        COLLECT: begin
          if (stream.in_valid && stream.in_ready) begin
            word_reg[{lane_reg, 3'b000} +: 8] <= stream.in_data;
            lane_reg <= lane_reg + 3'd1;
            len_reg  <= len_reg + 8'd1;
            if (lane_reg == 3'd7) begin
              state           <= COMP;
              last_pending    <= stream.in_last;
              stream.in_ready <= 1'b0;
              core_compress   <= 1'b1;
            end else if (stream.in_last) begin
              state           <= PAD;
              stream.in_ready <= 1'b0;
            end
          end
        end
        COMP: state <= CWAIT;
        CWAIT: begin
          if (core_ready) begin
            word_reg <= 64'd0;
            lane_reg <= 3'd0;
            if (last_pending) begin
              state <= PAD;
            end else begin
              state           <= COLLECT;
              stream.in_ready <= 1'b1;
            end
          end
        end
        PAD: begin
          // Lane 7 is always free here, so the length byte never overwrites data.
          word_reg[63:56] <= len_reg;
          last_pending    <= 1'b0;
          state           <= FCOMP;
          core_compress   <= 1'b1;
        end
        FCOMP: state <= FWAIT;
        FWAIT: begin
          if (core_ready) begin
            state         <= FIN;
            core_finalize <= 1'b1;
          end
        end
        FIN: state <= DWAIT;
        DWAIT: begin
          if (core_ready && core_word_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          busy            <= 1'b0;
          stream.in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef SIPHASH_PADDER_STATS_EN
  logic [31:0] blocks_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blocks_q <= 32'd0;
    end else if (core_compress) begin
      blocks_q <= blocks_q + 32'd1;
    end
  end

  assign blocks_ctr = blocks_q;
`else
  assign blocks_ctr = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_siphash_padder.sv
//==============================================================================
// tb_siphash_padder: drives byte messages into the padder against a SipHash-2-4 core stub
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps

module tb_siphash_padder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  siphash_padder_if stream ();

  logic        core_initalize, core_compress, core_finalize;
  logic [63:0] core_mi;
  logic        core_ready, core_word_valid;
  logic        busy, done;
  logic [31:0] blocks_ctr;

  siphash_padder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stream          (stream),
    .core_initalize  (core_initalize),
    .core_compress   (core_compress),
    .core_finalize   (core_finalize),
    .core_mi         (core_mi),
    .core_ready      (core_ready),
    .core_word_valid (core_word_valid),
    .busy            (busy),
    .done            (done),
    .blocks_ctr      (blocks_ctr)
  );

  // SipHash-2-4 reference arithmetic for the core stub
  localparam logic [63:0] K0 = 64'h0706050403020100;
  localparam logic [63:0] K1 = 64'h0f0e0d0c0b0a0908;

  function automatic logic [63:0] rotl(input logic [63:0] x, input int b);
    return (x << b) | (x >> (64 - b));
  endfunction

  function automatic logic [255:0] sipround(input logic [255:0] s);
    logic [63:0] v0, v1, v2, v3;
    {v0, v1, v2, v3} = s;
    v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
    v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
    v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
    v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
    return {v0, v1, v2, v3};
  endfunction

  function automatic logic [255:0] sip_init();
    return {K0 ^ 64'h736f6d6570736575, K1 ^ 64'h646f72616e646f6d,
            K0 ^ 64'h6c7967656e657261, K1 ^ 64'h7465646279746573};
  endfunction

  function automatic logic [255:0] sip_comp(input logic [255:0] s, input logic [63:0] m);
    logic [255:0] t;
    t = s;
    t[63:0] = t[63:0] ^ m;
    t = sipround(sipround(t));
    t[255:192] = t[255:192] ^ m;
    return t;
  endfunction

  function automatic logic [255:0] sip_fin(input logic [255:0] s);
    logic [255:0] t;
    t = s;
    t[127:64] = t[127:64] ^ 64'hff;
    for (int r = 0; r < 4; r++) t = sipround(t);
    return t;
  endfunction

  logic [255:0] sip;
  logic [63:0]  digest;
  int           lat_cnt;
  logic         fin_pend;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready      <= 1'b1;
      core_word_valid <= 1'b0;
      sip             <= '0;
      digest          <= '0;
      lat_cnt         <= 0;
      fin_pend        <= 1'b0;
    end else begin
      if (core_initalize) begin
        sip             <= sip_init();
        core_word_valid <= 1'b0;
      end
      if (core_compress) begin
        sip        <= sip_comp(sip, core_mi);
        core_ready <= 1'b0;
        lat_cnt    <= int'($urandom_range(1, 4));
      end else if (core_finalize) begin
        sip        <= sip_fin(sip);
        core_ready <= 1'b0;
        lat_cnt    <= int'($urandom_range(1, 4));
        fin_pend   <= 1'b1;
      end else if (!core_ready) begin
        if (lat_cnt > 1) begin
          lat_cnt <= lat_cnt - 1;
        end else begin
          core_ready <= 1'b1;
          if (fin_pend) begin
            core_word_valid <= 1'b1;
            digest          <= sip[255:192] ^ sip[191:128] ^ sip[127:64] ^ sip[63:0];
            fin_pend        <= 1'b0;
          end
        end
      end
    end
  end

  // Passive monitor; the main sequence only takes snapshots of these.
  logic [63:0] obs_q[$];
  int cyc = 0, init_cnt = 0, fin_cnt = 0, done_cnt = 0;
  int rdy_hi = 0, clash = 0, wv_cyc = 0, done_cyc = 0;
  logic wv_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (core_compress) obs_q.push_back(core_mi);
    if (core_initalize) init_cnt <= init_cnt + 1;
    if (core_finalize) fin_cnt <= fin_cnt + 1;
    if (stream.in_ready) rdy_hi <= rdy_hi + 1;
    if (stream.in_ready && (core_compress || core_finalize || core_initalize)) clash <= clash + 1;
    if (core_word_valid && !wv_prev) wv_cyc <= cyc;
    wv_prev <= core_word_valid;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int checks = 0;
  int errors = 0;
  int total_comp = 0;
  logic [7:0] msg_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_blocks(input string tag);
`ifdef SIPHASH_PADDER_STATS_EN
    check(tag, 64'(blocks_ctr), 64'(total_comp));
`else
    check(tag, 64'(blocks_ctr), 64'd0);
`endif
  endtask

  // Runs msg_q as one message and checks every word, pulse count and the done timing.
  task automatic run_msg(input bit empty, input bit cont, input string tag);
    logic [63:0] exp_q[$];
    logic [63:0] w;
    int n, nw, i, b, base_obs, base_init, base_fin, base_done, base_rdy;
    bit acc;
    n  = msg_q.size();
    nw = n / 8 + 1;
    for (int k = 0; k < nw; k++) begin
      w = 64'd0;
      for (int j = 0; j < 8; j++)
        if (8 * k + j < n) w = w | (64'(msg_q[8 * k + j]) << (8 * j));
      if (k == nw - 1) w = w | (64'(n % 256) << 56);
      exp_q.push_back(w);
    end
    base_obs  = obs_q.size();
    base_init = init_cnt;
    base_fin  = fin_cnt;
    base_done = done_cnt;
    base_rdy  = rdy_hi;

    stream.start       = 1'b1;
    stream.start_empty = empty;
    @(negedge clk);
    stream.start       = 1'b0;
    stream.start_empty = 1'b0;
    check({tag, "_init_lat"}, 64'(core_initalize), 64'd1);

    i = 0;
    b = 0;
    while (i < n && b < 5000) begin
      stream.in_valid = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
      stream.in_data  = msg_q[i];
      stream.in_last  = (i == n - 1);
      acc = stream.in_valid && stream.in_ready;
      @(negedge clk);
      if (acc) i++;
      b++;
    end
    stream.in_valid = 1'b0;
    stream.in_last  = 1'b0;
    if (i != n) check({tag, "_feed_timeout"}, 64'(i), 64'(n));

    b = 0;
    while (done_cnt == base_done && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_done"}, 64'(done_cnt - base_done), 64'd1);
    check({tag, "_n_words"}, 64'(obs_q.size() - base_obs), 64'(nw));
    for (int k = 0; k < nw; k++)
      if (base_obs + k < obs_q.size())
        check($sformatf("%s_mi%0d", tag, k), obs_q[base_obs + k], exp_q[k]);
    check({tag, "_n_init"}, 64'(init_cnt - base_init), 64'd1);
    check({tag, "_n_fin"}, 64'(fin_cnt - base_fin), 64'd1);
    check({tag, "_done_lat"}, 64'(done_cyc - wv_cyc), 64'd1);
    if (empty) check({tag, "_in_ready_low"}, 64'(rdy_hi - base_rdy), 64'd0);
    total_comp += nw;
    @(negedge clk);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check_blocks({tag, "_blocks"});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int i, b, base_clash, base_obs;
    bit acc;
    stream.start       = 1'b0;
    stream.start_empty = 1'b0;
    stream.in_valid    = 1'b0;
    stream.in_data     = 8'h00;
    stream.in_last     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(stream.in_ready), 64'd0);
    check("rst_pulses", 64'({core_initalize, core_compress, core_finalize, done}), 64'd0);
    check("rst_mi", core_mi, 64'd0);
    check("rst_blocks", 64'(blocks_ctr), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    msg_q.delete();
    msg_q.push_back(8'h00);
    run_msg(1'b0, 1'b0, "one_byte");

    msg_q.delete();
    for (int k = 0; k < 8; k++) msg_q.push_back(8'(k));
    run_msg(1'b0, 1'b0, "eight");

    msg_q.delete();
    for (int k = 0; k < 15; k++) msg_q.push_back(8'(k));
    run_msg(1'b0, 1'b1, "fifteen");
    check("fifteen_digest", digest, 64'ha129ca6149be45e5);

    msg_q.delete();
    run_msg(1'b1, 1'b0, "empty");

    msg_q.delete();
    for (int k = 0; k < 256; k++) msg_q.push_back(8'($urandom));
    base_clash = clash;
    base_obs   = obs_q.size();
    run_msg(1'b0, 1'b1, "len256");
    check("len256_ready_clash", 64'(clash - base_clash), 64'd0);
    check("len256_n_comp", 64'(obs_q.size() - base_obs), 64'd33);
    check("len256_last_mi", obs_q[obs_q.size() - 1], 64'd0);

    for (int r = 0; r < 6; r++) begin
      msg_q.delete();
      b = int'($urandom_range(1, 40));
      for (int k = 0; k < b; k++) msg_q.push_back(8'($urandom));
      run_msg(1'b0, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end

    // Abort mid-message while the core is busy with a compress
    stream.start = 1'b1;
    @(negedge clk);
    stream.start = 1'b0;
    i = 0;
    b = 0;
    while (i < 8 && b < 100) begin
      stream.in_valid = 1'b1;
      stream.in_data  = 8'(8'h40 + i);
      stream.in_last  = 1'b0;
      acc = stream.in_ready;
      @(negedge clk);
      if (acc) i++;
      b++;
    end
    stream.in_valid = 1'b0;
    check("abort_comp", 64'(core_compress), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(stream.in_ready), 64'd0);
    check("abort_mi", core_mi, 64'd0);
    check("abort_blocks", 64'(blocks_ctr), 64'd0);
    total_comp = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    msg_q.delete();
    msg_q.push_back(8'ha5);
    run_msg(1'b0, 1'b0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/siphash_padder.md
# siphash_padder

Message front-end for the SipHash core. Accepts a message as a byte stream with valid/ready handshake, packs bytes little-endian into 64-bit words, appends the SipHash length/zero padding to the final word, and sequences the core's initalize / compress / finalize controls, waiting on the core's `ready` between operations. It sits directly upstream of the core. The key and round counts go straight to the core and do not pass through this block.

## Interface
- No parameters.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new message; sampled only in IDLE.
- `start_empty` in 1: sampled with `start`; the message has zero bytes.
- `in_valid` in 1: byte valid.
- `in_ready` out 1: byte accepted when `in_valid & in_ready`.
- `in_data` in 8: message byte.
- `in_last` in 1: final byte of the message; qualified by the handshake.
- `core_initalize` out 1: one-cycle pulse to the core.
- `core_compress` out 1: one-cycle pulse to the core.
- `core_finalize` out 1: one-cycle pulse to the core.
- `core_mi` out 64: message word; valid while `core_compress=1`.
- `core_ready` in 1: core ready.
- `core_word_valid` in 1: core digest valid.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the digest is available from the core.
- `blocks_ctr` out 32: count of compress pulses issued (see Configuration).

## Operation
- Registers:
  - `word_reg[63:0]`, cleared after each compress completes.
  - `lane_reg[2:0]`: next byte lane.
  - `len_reg[7:0]`: message length mod 256; wraps; cleared on `start`.
  - `last_pending`: a compress was issued for a full word that held the last byte.
- Moore FSM. Core control outputs and `in_ready` decode from state only.
- **IDLE:** when `start` and `core_ready` -> INIT. Clear `len_reg`, `lane_reg`, `word_reg`; latch `start_empty`.
- **INIT:** `core_initalize=1`. Next state is PAD if empty, otherwise COLLECT.
- **COLLECT:** `in_ready=1`. On handshake:
  - `word_reg[8*lane+:8]=in_data`; `lane_reg++`; `len_reg++`.
  - If lane was 7 -> COMP, with `last_pending=in_last`.
  - Else if `in_last` -> PAD.
- **COMP:** `core_compress=1`, `core_mi=word_reg` -> CWAIT.
- **CWAIT:** wait for `core_ready=1`, then clear `word_reg` and `lane_reg`. Next state is PAD if `last_pending`, else COLLECT.
- **PAD:**
  - `word_reg[63:56]=len_reg`. Unfilled lanes are already zero. Lane 7 is never occupied here.
  - Clear `last_pending` -> FCOMP.
- **FCOMP:** `core_compress=1`, `core_mi=word_reg` -> FWAIT.
- **FWAIT:** on `core_ready` -> FIN.
- **FIN:** `core_finalize=1` -> DWAIT.
- **DWAIT:** on `core_ready & core_word_valid` -> DONE.
- **DONE:** `done=1` -> IDLE.
- Padding follows from the above:
  - Length that is a multiple of 8 (including 0): the final word is `{len_reg, 56'h0}`.
  - Otherwise: the remaining bytes occupy the low lanes and the length byte sits in lane 7.
- `start` outside IDLE is ignored. `in_valid` outside COLLECT is held off by `in_ready=0`.
- `in_last` on a 0-byte message is impossible; use `start_empty`.

## Timing
- Reset values:
  - All outputs 0; `core_mi=0`; `blocks_ctr=0`.
  - FSM in IDLE; all internal registers 0.
- Reset asserted mid-message aborts to IDLE immediately. The core shares `reset_n`.
- Throughput: at most one byte per cycle in COLLECT. Each full word costs COMP + CWAIT, i.e. 2 + core round cycles.
- In the cycle after a compress or finalize pulse, the core drives `core_ready=0`. Waiting for `core_ready=1` in CWAIT, FWAIT and DWAIT is therefore safe from the first cycle; no guard cycle is needed.
- Latency from `start` to `core_initalize` is 1 cycle. `done` follows `core_word_valid` rising by 1 cycle.

## Configuration
- `SIPHASH_PADDER_STATS_EN` defined:
  - `blocks_ctr` increments on every `core_compress` pulse (COMP and FCOMP).
  - It wraps at 2^32 and clears only on reset.
- `SIPHASH_PADDER_STATS_EN` not defined: the counter is not built and `blocks_ctr` is tied to 0.

## Test plan
- 1 byte `0x00` with `in_last` -> one compress with mi=`0x0100000000000000`, then finalize, then `done`.
- 8 bytes `00..07` (last on `07`) -> mi=`0x0706050403020100`, then mi=`0x0800000000000000`; with STATS, `blocks_ctr=2`.
- 15 bytes `00..0e`, key `000102..0f`, core at 2-4 rounds -> second mi=`0x0F0E0D0C0B0A0908`; digest `0xa129ca6149be45e5`.
- `start` with `start_empty=1` -> a single compress with mi=`0x0000000000000000`, then finalize; `in_ready` stays 0 throughout.
- 256-byte message with `in_valid` held continuously -> `in_ready` low in COMP/CWAIT; final mi=`0x0000000000000000` (length wraps to 0); 33 compresses.
- `reset_n` pulsed low while in CWAIT -> `busy=0`, `in_ready=0`, FSM in IDLE; a following 1-byte message hashes correctly.
